// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte sender (clock inhibit, start, 8 data LSB first, odd parity, stop, ACK).
// Takes one byte per transfer, only while idle. The optional watchdog abort is enabled by PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       tx_timeout
);

  // One counter times the inhibit window and, when enabled, the watchdog.
  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE, DONE} state_t;

  state_t        state;
  logic          clk_meta, clk_sync, clk_prev;
  logic          data_meta, data_sync;
  logic          clk_fall;
  logic [7:0]    data_q;
  logic          parity_q;
  logic [3:0]    edge_cnt;
  logic [CW-1:0] cnt;
  logic          ack_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_i;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_i;
      data_sync <= data_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;
  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic timeout_q;
  assign tx_timeout = timeout_q;
`else
  assign tx_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      data_q      <= '0;
      parity_q    <= 1'b0;
      edge_cnt    <= '0;
      cnt         <= '0;
      ack_err     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (tx_valid) begin
            data_q      <= tx_data;
            parity_q    <= ~^tx_data;
            edge_cnt    <= '0;
            cnt         <= '0;
            ack_err     <= 1'b0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            state       <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b1;
            state       <= REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REQ: begin
          ps2_clk_oe <= 1'b0;
          state      <= BITS;
        end
        BITS: begin
          // Line is driven with the inverse of the bit: oe=1 pulls the open-drain low.
          if (clk_fall) begin
            edge_cnt <= edge_cnt + 4'd1;
            if (edge_cnt < 4'd8) begin
              ps2_data_oe <= ~data_q[edge_cnt[2:0]];
            end else if (edge_cnt == 4'd8) begin
              ps2_data_oe <= ~parity_q;
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= ACK;
            end
          end
        end
        ACK: begin
          if (clk_fall) begin
            ack_err <= data_sync;
            state   <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (clk_sync && data_sync) begin
            tx_done <= 1'b1;
            tx_err  <= ack_err;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog overrides any transition taken above in the same cycle.
      if (state inside {REQ, BITS, ACK, WAIT_IDLE}) begin
        cnt <= cnt + 1'b1;
        if (cnt == TO_LAST) begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_done     <= 1'b1;
          tx_err      <= 1'b0;
          timeout_q   <= 1'b1;
          state       <= DONE;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain PS/2 device model plus a timeline model of the host outputs.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TO  = 500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err, tx_timeout;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_line, data_line;

  assign clk_line  = !(ps2_clk_oe || dev_clk_low);
  assign data_line = !(ps2_data_oe || dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_i(clk_line), .ps2_data_i(data_line), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .tx_done(tx_done), .tx_err(tx_err), .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0, acc_cyc = 0, rel_cyc = 0;
  int done_cnt = 0, err_cnt = 0, to_cnt = 0;
  bit tracking = 0, model_idle = 1, done_pending = 0, exp_err = 0, silent = 0, rst_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  // Timeline model: after the accept cycle k=0, the clock is held low for INH+1 cycles,
  // the start bit appears on the last of them, and the done pulse follows the device release.
  always @(negedge clk) begin : mon
    int k;
    bit was_idle;
    cyc++;
    k = cyc - acc_cyc;
    was_idle = model_idle;
    if (rst_chk) begin
      chk1("rst_clk_oe", ps2_clk_oe, 1'b0);
      chk1("rst_data_oe", ps2_data_oe, 1'b0);
      chk1("rst_tx_ready", tx_ready, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk("rst_flags", 32'({tx_done, tx_err, tx_timeout}), 32'd0);
      rst_chk = 0;
    end
    chk1("tx_ready", tx_ready, model_idle);
    chk1("busy", busy, !model_idle);
    chk1("clk_oe", ps2_clk_oe, tracking && k >= 1 && k <= INH + 1);
    if (!tracking || k <= INH + 1) chk1("data_oe", ps2_data_oe, tracking && k == INH + 1);
    if (!tracking) begin
      chk("no_done_idle", 32'({tx_done, tx_err, tx_timeout}), 32'd0);
    end else if (!tx_done) begin
      chk("no_stray_flags", 32'({tx_err, tx_timeout}), 32'd0);
      if (done_pending && cyc - rel_cyc > 10) begin
        chk1("done_latency", tx_done, 1'b1);
        tracking = 0; done_pending = 0; model_idle = 1;
      end
    end else begin
      done_cnt++;
      if (tx_err) err_cnt++;
      if (tx_timeout) to_cnt++;
      if (silent) begin
        chk("timeout_cycle", k, INH + 1 + TO);
        chk1("timeout_flag", tx_timeout, 1'b1);
        chk1("timeout_err", tx_err, 1'b0);
      end else begin
        chk1("done_early", tx_done, done_pending);
        chk1("tx_err", tx_err, exp_err);
        chk1("tx_timeout", tx_timeout, 1'b0);
      end
      chk1("done_clk_rel", ps2_clk_oe, 1'b0);
      chk1("done_data_rel", ps2_data_oe, 1'b0);
      tracking = 0; done_pending = 0; silent = 0; model_idle = 1;
    end
    if (rst) begin
      tracking = 0; done_pending = 0; silent = 0; model_idle = 1; rst_chk = 1;
    end else if (tx_valid && was_idle) begin
      tracking = 1; acc_cyc = cyc; model_idle = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = b;
    @(posedge clk); #1 tx_valid = 1'b0; tx_data = 8'($urandom);
  endtask

  task automatic wait_idle(input int limit);
    int w = 0;
    while (!model_idle && w < limit) begin @(posedge clk); #1; w++; end
    chk1("reached_idle", tx_ready, 1'b1);
  endtask

  // Device side: clocks 11 falling edges, samples the line on rising edges 1..10, ACKs on edge 11.
  task automatic xfer(input logic [7:0] b, input bit ack, input int half, input int abort_fall,
                      input bit poke, output logic [9:0] cap);
    int w;
    cap = '0;
    exp_err = !ack;
    send(b);
    w = 0;
    while (!(clk_line && !data_line) && w < 200) begin @(posedge clk); #1; w++; end
    chk("start_bit", 32'({clk_line, data_line}), 32'b10);
    if (w >= 200) return;
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && ack) begin @(posedge clk); #1 dev_data_low = 1'b1; end
      if (poke && i == 3) begin
        @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'hAA;
        @(posedge clk); #1 tx_valid = 1'b0;
      end
      repeat (half) @(posedge clk);
      #1 dev_clk_low = 1'b1;
      if (i + 1 == abort_fall) begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (half) @(posedge clk);
        #1 dev_clk_low = 1'b0;
        return;
      end
      repeat (half) @(posedge clk);
      #1 dev_clk_low = 1'b0;
      if (i < 10) cap[i] = data_line;
    end
    repeat (2) @(posedge clk);
    #1 dev_data_low = 1'b0;
    rel_cyc = cyc;
    done_pending = 1;
    chk("frame", 32'(cap), 32'({1'b1, ($countones(b) % 2 == 0), b}));
    wait_idle(50);
  endtask

  initial begin : main
    logic [9:0] cap;
    logic [7:0] b;
    bit ack;
    int half, d0, e0, t0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    xfer(8'hED, 1'b1, 15, 0, 1'b0, cap);
    chk("frame_ED", 32'(cap), 32'h3ED);
    xfer(8'h07, 1'b1, 12, 0, 1'b0, cap);
    chk("frame_07", 32'(cap), 32'h207);
    xfer(8'h00, 1'b1, 10, 0, 1'b0, cap);
    chk("frame_00", 32'(cap), 32'h300);

    e0 = err_cnt; d0 = done_cnt;
    xfer(8'h3C, 1'b0, 14, 0, 1'b0, cap);
    chk("nack_err_pulses", err_cnt - e0, 1);
    chk("nack_done_pulses", done_cnt - d0, 1);

    d0 = done_cnt;
    xfer(8'h5A, 1'b1, 14, 0, 1'b1, cap);
    chk("busy_ignore_frame", 32'(cap), 32'h35A);
    repeat (80) @(posedge clk);
    chk("busy_ignore_dones", done_cnt - d0, 1);

    d0 = done_cnt;
    xfer(8'hC3, 1'b1, 12, 5, 1'b0, cap);
    repeat (60) @(posedge clk);
    chk("abort_no_done", done_cnt - d0, 0);

    t0 = to_cnt;
    silent = 1;
    send(8'h96);
`ifdef PS2_TX_TIMEOUT_EN
    wait_idle(INH + TO + 100);
    chk("timeout_pulses", to_cnt - t0, 1);
`else
    repeat (1500) @(posedge clk);
    #1;
    chk1("silent_busy", busy, 1'b1);
    chk("silent_no_timeout", to_cnt - t0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
`endif

    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      ack = ($urandom_range(0, 3) != 0);
      half = int'($urandom_range(8, 18));
      repeat (int'($urandom_range(0, 5))) @(posedge clk);
      xfer(b, ack, half, 0, 1'b0, cap);
    end

    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : guard
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "simulation time limit reached");
  end

endmodule
